fetch_decode_ctrl: RTL

- Upstream control stage of the single-issue RISC-V datapath.
- Owns the PC and fetches instructions from instruction memory over a req/ack handshake.
- Holds each instruction in an instruction register and decodes it into the datapath controls: RegWrite, ALUsrc, ALUctrl, immOp, Resultsrc, rs1/rs2/rd.
- Consumes the ALU's EQ flag to resolve beq/bne and select the next PC.

---
 rtl/riscv_pkg.sv | 20 ++
 rtl/fetch_decode_ctrl_decoder.sv | 99 +++++++++
 rtl/fetch_decode_ctrl.sv | 127 ++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared constants for the RV32I subset: opcodes, ALU control codes, fetch FSM states.
package riscv_pkg;

    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        EXEC  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/fetch_decode_ctrl_decoder.sv
// Combinational decode of one instruction word into datapath controls.
module fetch_decode_ctrl_decoder
    import riscv_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int ADDRESS_WIDTH = 5
) (
    input  logic [DATA_WIDTH-1:0]    ir_i,
    output logic                     regwrite_o,
    output logic                     alusrc_o,
    output logic [2:0]               aluctrl_o,
    output logic [DATA_WIDTH-1:0]    imm_o,
    output logic                     resultsrc_o,
    output logic                     beq_o,
    output logic                     bne_o,
    output logic                     illegal_o,
    output logic [ADDRESS_WIDTH-1:0] rs1_o,
    output logic [ADDRESS_WIDTH-1:0] rs2_o,
    output logic [ADDRESS_WIDTH-1:0] rd_o
);

    logic [6:0]            opcode;
    logic [2:0]            f3;
    logic [6:0]            f7;
    logic [DATA_WIDTH-1:0] imm_i;
    logic [DATA_WIDTH-1:0] imm_b;

    assign opcode = ir_i[6:0];
    assign f3     = ir_i[14:12];
    assign f7     = ir_i[31:25];
    assign imm_i  = {{(DATA_WIDTH-12){ir_i[31]}}, ir_i[31:20]};
    assign imm_b  = {{(DATA_WIDTH-13){ir_i[31]}}, ir_i[31], ir_i[7], ir_i[30:25], ir_i[11:8], 1'b0};

    // Register fields are passed through for every encoding.
    assign rs1_o = ir_i[15 +: ADDRESS_WIDTH];
    assign rs2_o = ir_i[20 +: ADDRESS_WIDTH];
    assign rd_o  = ir_i[7 +: ADDRESS_WIDTH];

    // Opcode/funct decode; anything not matched is flagged illegal with all controls idle.
    always_comb begin
        regwrite_o  = 1'b0;
        alusrc_o    = 1'b0;
        aluctrl_o   = ALU_ADD;
        imm_o       = '0;
        resultsrc_o = 1'b0;
        beq_o       = 1'b0;
        bne_o       = 1'b0;
        illegal_o   = 1'b0;
        case (opcode)
            OP_IMM: begin
                if (f3 == 3'b000) begin
                    regwrite_o = 1'b1;
                    alusrc_o   = 1'b1;
                    imm_o      = imm_i;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OP_REG: begin
                if (f3 == 3'b000 && f7 == 7'b0000000) begin
                    regwrite_o = 1'b1;
                end else if (f3 == 3'b000 && f7 == 7'b0100000) begin
                    regwrite_o = 1'b1;
                    aluctrl_o  = ALU_SUB;
                end else if (f3 == 3'b111 && f7 == 7'b0000000) begin
                    regwrite_o = 1'b1;
                    aluctrl_o  = ALU_AND;
                end else if (f3 == 3'b110 && f7 == 7'b0000000) begin
                    regwrite_o = 1'b1;
                    aluctrl_o  = ALU_OR;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OP_LOAD: begin
                if (f3 == 3'b010) begin
                    regwrite_o  = 1'b1;
                    alusrc_o    = 1'b1;
                    resultsrc_o = 1'b1;
                    imm_o       = imm_i;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OP_BRANCH: begin
                if (f3 == 3'b000 || f3 == 3'b001) begin
                    aluctrl_o = ALU_SUB;
                    imm_o     = imm_b;
                    beq_o     = (f3 == 3'b000);
                    bne_o     = (f3 == 3'b001);
                end else begin
                    illegal_o = 1'b1;
                end
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/fetch_decode_ctrl.sv
// Fetch/decode control: PC, instruction register, imem handshake FSM with ack timeout.
module fetch_decode_ctrl
    import riscv_pkg::*;
#(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    ADDRESS_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] RESET_PC      = '0,
    parameter int                    ACK_TIMEOUT   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    output logic                     imem_req,
    output logic [DATA_WIDTH-1:0]    imem_addr,
    input  logic                     imem_ack,
    input  logic [DATA_WIDTH-1:0]    imem_rdata,
    input  logic                     EQ,
    output logic                     RegWrite,
    output logic                     ALUsrc,
    output logic [2:0]               ALUctrl,
    output logic [DATA_WIDTH-1:0]    immOp,
    output logic                     Resultsrc,
    output logic [ADDRESS_WIDTH-1:0] rs1,
    output logic [ADDRESS_WIDTH-1:0] rs2,
    output logic [ADDRESS_WIDTH-1:0] rd,
    output logic [DATA_WIDTH-1:0]    pc,
    output logic                     illegal,
    output logic                     fetch_err
);

    localparam int              CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    fetch_state_t          state_q, state_d;
    logic [DATA_WIDTH-1:0] pc_q, pc_d;
    logic [DATA_WIDTH-1:0] ir_q, ir_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  illegal_q, illegal_d;
    logic                  fetch_err_q, fetch_err_d;
    logic                  req_c;

    logic dec_rw, dec_beq, dec_bne, dec_illegal, taken;

    fetch_decode_ctrl_decoder #(
        .DATA_WIDTH   (DATA_WIDTH),
        .ADDRESS_WIDTH(ADDRESS_WIDTH)
    ) u_dec (
        .ir_i       (ir_q),
        .regwrite_o (dec_rw),
        .alusrc_o   (ALUsrc),
        .aluctrl_o  (ALUctrl),
        .imm_o      (immOp),
        .resultsrc_o(Resultsrc),
        .beq_o      (dec_beq),
        .bne_o      (dec_bne),
        .illegal_o  (dec_illegal),
        .rs1_o      (rs1),
        .rs2_o      (rs2),
        .rd_o       (rd)
    );

    assign taken = (dec_beq & EQ) | (dec_bne & ~EQ);

    // Next-state logic: FETCH issues, WAIT collects ack or times out, EXEC advances the PC.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        cnt_d       = cnt_q;
        illegal_d   = illegal_q;
        fetch_err_d = 1'b0;
        req_c       = 1'b0;
        case (state_q)
            FETCH: begin
                // A stale ack here is deliberately ignored.
                req_c   = 1'b1;
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                req_c = 1'b1;
                cnt_d = cnt_q + 1'b1;
                if (imem_ack) begin
                    // Ack takes priority over a timeout in the same cycle.
                    ir_d    = imem_rdata;
                    state_d = EXEC;
                end else if (cnt_q == CNT_LAST) begin
                    fetch_err_d = 1'b1;
                    state_d     = FETCH;
                end
            end
            EXEC: begin
                pc_d    = pc_q + (taken ? immOp : DATA_WIDTH'(4));
                state_d = FETCH;
                if (dec_illegal) illegal_d = 1'b1;
            end
            default: state_d = FETCH;
        endcase
    end

    // State, PC, IR and status registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            ir_q        <= DATA_WIDTH'(32'h0000_0013);
            cnt_q       <= '0;
            illegal_q   <= 1'b0;
            fetch_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            cnt_q       <= cnt_d;
            illegal_q   <= illegal_d;
            fetch_err_q <= fetch_err_d;
        end
    end

    // Request and write enable are forced low while reset is held.
    assign imem_req  = req_c & ~rst;
    assign RegWrite  = dec_rw & (state_q == EXEC) & ~rst;
    assign imem_addr = pc_q;
    assign pc        = pc_q;
    assign illegal   = illegal_q;
    assign fetch_err = fetch_err_q;

endmodule
